spi_mem_arbiter: RTL and testbench

//  Shares the single SPI flash read engine between two requesters: instruction fetch (IF) and data load (DM).

---
 rtl/spi_mem_arbiter_pkg.sv | 21 ++
 rtl/spi_mem_arbiter_rr_pick2.sv | 27 ++
 rtl/spi_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_arbiter_pkg.sv
// Shared definitions for the SPI flash read arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   ARB_ID_*    : requester identifiers (IF = instruction fetch, DM = data load)
//   other_id()  : the requester that is not the given one
package spi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam logic ARB_ID_IF = 1'b0;
  localparam logic ARB_ID_DM = 1'b1;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_i[0]    : IF requesting, req_i[1] : DM requesting
//   last_i      : id granted most recently
//   gnt_valid_o : at least one requester pending
//   gnt_id_o    : chosen requester; when both pend, the one not granted last
module spi_mem_arbiter_rr_pick2
  import spi_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Winner selection
  always_comb begin
    gnt_valid_o = req_i[0] | req_i[1];
    gnt_id_o    = ARB_ID_IF;
    case (req_i)
      2'b01:   gnt_id_o = ARB_ID_IF;
      2'b10:   gnt_id_o = ARB_ID_DM;
      2'b11:   gnt_id_o = other_id(last_i);
      default: gnt_id_o = ARB_ID_IF;
    endcase
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates the single SPI flash read engine between instruction fetch (IF)
// and data load (DM). One transaction in flight, round-robin grants, response
// watchdog that aborts the engine, all outputs registered.
// Optional feature macro FETCH_CACHE_EN adds a one-entry IF result cache.
// Ports:
//   clk, rst_n              clock / async active-low reset
//   ena                     0 blocks new grants
//   if_req/if_addr          fetch request (level, held until if_ack)
//   if_ack/if_rdata/if_err  fetch response pulse, data, timeout flag
//   dm_*                    same set for data loads
//   mem_start/mem_addr      engine launch pulse and held address
//   mem_done/mem_rdata      engine completion pulse and data
//   mem_abort               watchdog abort pulse to engine
//   cache_flush             invalidate fetch cache
//   busy                    arbiter not idle
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_abort,
  input  logic              cache_flush,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // WAIT cycle k (k = 1, 2, ...) holds count k-1, so this value marks the
  // TIMEOUT_CYC-th cycle after mem_start: the last one where done is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}};

  arb_state_e        state_q;
  logic              last_q;
  logic              id_q;
  logic              dropped_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_start_q, mem_abort_q, busy_q;
  logic              if_ack_q, dm_ack_q, if_err_q, dm_err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic              gnt_valid_s, gnt_id_s;
  logic              win_req_s, keep_s;
  logic [DATA_W-1:0] resp_data_s;
  logic              resp_err_s;
  logic              hit_s;
  logic [DATA_W-1:0] c_data_s;

  spi_mem_arbiter_rr_pick2 u_pick (
    .req_i       ({dm_req, if_req}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // The response is delivered only if the winner has held its request throughout.
  assign win_req_s   = (id_q == ARB_ID_DM) ? dm_req : if_req;
  assign keep_s      = win_req_s & ~dropped_q;
  assign resp_data_s = mem_done ? mem_rdata : ERR_DATA;
  assign resp_err_s  = ~mem_done;

`ifdef FETCH_CACHE_EN
  logic              c_valid_q;
  logic [ADDR_W-1:0] c_tag_q;
  logic [DATA_W-1:0] c_data_q;
  logic              fill_s;

  assign hit_s    = c_valid_q && (c_tag_q == if_addr);
  assign c_data_s = c_data_q;
  assign fill_s   = ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) && mem_done &&
                    (id_q == ARB_ID_IF) && keep_s;

  // Fetch cache entry; flush takes priority over a same-cycle fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else if (cache_flush) begin
      c_valid_q <= 1'b0;
    end else if (fill_s) begin
      c_valid_q <= 1'b1;
      c_tag_q   <= mem_addr_q;
      c_data_q  <= mem_rdata;
    end
  end
`else
  logic unused_flush_s;
  assign unused_flush_s = cache_flush;
  assign hit_s          = 1'b0;
  assign c_data_s       = '0;
`endif

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      last_q      <= ARB_ID_DM;
      id_q        <= ARB_ID_IF;
      dropped_q   <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_start_q <= 1'b0;
      mem_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_start_q <= 1'b0;
      mem_abort_q <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (ena && gnt_valid_s) begin
            id_q      <= gnt_id_s;
            last_q    <= gnt_id_s;
            dropped_q <= 1'b0;
            busy_q    <= 1'b1;
            if ((gnt_id_s == ARB_ID_IF) && hit_s) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= c_data_s;
              state_q    <= ARB_RESP;
            end else begin
              mem_addr_q  <= (gnt_id_s == ARB_ID_DM) ? dm_addr : if_addr;
              mem_start_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ARB_ISSUE;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ARB_ISSUE, ARB_WAIT: begin
          // done is checked before the watchdog so a same-cycle done wins
          if (mem_done || ((state_q == ARB_WAIT) && (cnt_q == CNT_LAST))) begin
            state_q     <= ARB_RESP;
            mem_abort_q <= ~mem_done;
            if (keep_s && (id_q == ARB_ID_DM)) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= resp_data_s;
              dm_err_q   <= resp_err_s;
            end else if (keep_s) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= resp_data_s;
              if_err_q   <= resp_err_s;
            end
          end else begin
            state_q   <= ARB_WAIT;
            cnt_q     <= (state_q == ARB_ISSUE) ? '0 : cnt_q + CNT_W'(1);
            dropped_q <= dropped_q | ~win_req_s;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_start = mem_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_abort = mem_abort_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed steps plus randomized
// transactions against a transaction-level reference model.
module tb_spi_mem_arbiter;

  localparam int T = 8;
`ifdef FETCH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, cache_flush = 1'b0;
  logic [15:0] if_addr = 16'h0, dm_addr = 16'h0;
  logic if_ack, if_err, dm_ack, dm_err, mem_start, mem_abort, busy;
  logic [15:0] if_rdata, dm_rdata, mem_addr;
  logic mem_done = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  spi_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_abort(mem_abort), .cache_flush(cache_flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // SPI engine responder: done D cycles after the start cycle, data = addr ^ eng_xor
  int eng_d = -1;
  int eng_cnt = -1;
  logic [15:0] eng_xor = 16'h0;
  bit force_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || mem_abort) eng_cnt = -1;
    if (mem_start && rst_n) eng_cnt = eng_d;
    mem_done  = force_done || (eng_cnt == 0);
    mem_rdata = mem_addr ^ eng_xor;
    if (eng_cnt >= 0) eng_cnt = eng_cnt - 1;
  end

  int errors = 0;
  int checks = 0;
  string step = "init";

  // reference model state
  bit m_last = 1'b1;            // 0 = IF, 1 = DM
  bit m_cv = 1'b0;
  logic [15:0] m_ctag = 16'h0, m_cdat = 16'h0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  // One request set (issued in cycle 0) run to completion and compared with the model
  task automatic txn(input bit rif, input bit rdm, input logic [15:0] aif, input logic [15:0] adm,
                     input int d, input int flush_rel, input int ena_drop_rel);
    int e_start[$]; logic [15:0] e_saddr[$]; int e_abort[$];
    int o_start[$]; logic [15:0] o_saddr[$]; int o_abort[$];
    int e_ack[2]; logic [15:0] e_dat[2]; logic e_err[2];
    int o_ack[2]; logic [15:0] o_dat[2]; logic o_err[2]; int o_nack[2];
    bit pend[2]; logic [15:0] a[2];
    int t; int g;
    pend[0] = rif; pend[1] = rdm; a[0] = aif; a[1] = adm; t = 0;
    for (int p = 0; p < 2; p++) begin
      e_ack[p] = -1; o_ack[p] = -1; o_nack[p] = 0;
      e_dat[p] = 16'h0; e_err[p] = 1'b0; o_dat[p] = 16'h0; o_err[p] = 1'b0;
    end
    while (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) g = m_last ? 0 : 1;
      else g = pend[1] ? 1 : 0;
      m_last = (g == 1);
      pend[g] = 1'b0;
      if (g == 0 && CACHE && m_cv && m_ctag == a[0]) begin
        e_ack[0] = t + 1; e_dat[0] = m_cdat; e_err[0] = 1'b0;
        t = t + 2;
      end else begin
        e_start.push_back(t + 1); e_saddr.push_back(a[g]);
        if (d <= T) begin
          e_ack[g] = t + 2 + d; e_dat[g] = a[g] ^ eng_xor; e_err[g] = 1'b0;
          if (g == 0 && CACHE) begin m_cv = 1'b1; m_ctag = a[0]; m_cdat = e_dat[0]; end
        end else begin
          e_ack[g] = t + 2 + T; e_dat[g] = 16'hFFFF; e_err[g] = 1'b1;
          e_abort.push_back(e_ack[g]);
        end
        t = e_ack[g] + 1;
      end
    end
    if (flush_rel >= 0) m_cv = 1'b0;

    eng_d = (d <= T) ? d : -1;
    if_addr = aif; dm_addr = adm; if_req = rif; dm_req = rdm;
    for (int rel = 1; rel <= t + 2; rel++) begin
      @(negedge clk);
      cache_flush = (rel == flush_rel);
      if (rel == ena_drop_rel) ena = 1'b0;
      if (mem_start) begin o_start.push_back(rel); o_saddr.push_back(mem_addr); end
      if (mem_abort) o_abort.push_back(rel);
      if (if_ack) begin
        o_nack[0]++;
        if (o_ack[0] < 0) begin o_ack[0] = rel; o_dat[0] = if_rdata; o_err[0] = if_err; end
        if_req = 1'b0;
      end
      if (dm_ack) begin
        o_nack[1]++;
        if (o_ack[1] < 0) begin o_ack[1] = rel; o_dat[1] = dm_rdata; o_err[1] = dm_err; end
        dm_req = 1'b0;
      end
    end
    cache_flush = 1'b0; if_req = 1'b0; dm_req = 1'b0;

    chk("n_start", o_start.size(), e_start.size());
    for (int i = 0; i < e_start.size() && i < o_start.size(); i++) begin
      chk("start_cyc", o_start[i], e_start[i]);
      chk("start_addr", o_saddr[i], e_saddr[i]);
    end
    chk("n_abort", o_abort.size(), e_abort.size());
    for (int i = 0; i < e_abort.size() && i < o_abort.size(); i++)
      chk("abort_cyc", o_abort[i], e_abort[i]);
    for (int p = 0; p < 2; p++) begin
      chk(p ? "dm_nack" : "if_nack", o_nack[p], (e_ack[p] >= 0) ? 1 : 0);
      if (e_ack[p] >= 0) begin
        chk(p ? "dm_ack_cyc" : "if_ack_cyc", o_ack[p], e_ack[p]);
        chk(p ? "dm_rdata" : "if_rdata", o_dat[p], e_dat[p]);
        chk(p ? "dm_err" : "if_err", o_err[p], e_err[p]);
        m_rd[p] = e_dat[p];
      end
    end
    chk("busy_end", busy, 1'b0);
  endtask

  task automatic flush_idle();
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    @(negedge clk);
    m_cv = 1'b0;
  endtask

  logic [15:0] tbl [4] = '{16'h0040, 16'h0100, 16'h0200, 16'h0300};

  initial begin
    int n, nack, kind;
    logic [15:0] ra, rb;
    step = "reset";
    repeat (3) @(negedge clk);
    chk("busy", busy, 1'b0);
    chk("mem_start", mem_start, 1'b0);
    chk("acks", {if_ack, dm_ack, mem_abort, if_err, dm_err}, 5'b0);
    chk("rdata", {if_rdata, dm_rdata}, 32'h0);
    chk("mem_addr", mem_addr, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_rel", busy, 1'b0);

    step = "pair1";   eng_xor = 16'h3C3C; txn(1, 1, 16'h0080, 16'h0090, 2, -1, -1);
    step = "if_only"; eng_xor = 16'hA54A; txn(1, 0, 16'h0010, 16'h0000, 3, -1, -1);
    step = "pair2";   eng_xor = 16'h1111; txn(1, 1, 16'h00A0, 16'h00B0, 1, -1, -1);
    step = "d0";      txn(0, 1, 16'h0000, 16'h00C0, 0, -1, -1);
    step = "d_eq_t";  txn(0, 1, 16'h0000, 16'h00D0, T, -1, -1);
    step = "timeout"; txn(0, 1, 16'h0000, 16'h00E0, T + 3, -1, -1);

    step = "late_done";
    @(posedge clk); #1 force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_ack || dm_ack || mem_abort || busy) n++;
    end
    chk("ignored", n, 0);

    step = "ena_off";
    ena = 1'b0; if_addr = 16'h0500; if_req = 1'b1; n = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_start || busy) n++;
    end
    chk("no_grant", n, 0);
    ena = 1'b1;
    txn(1, 0, 16'h0500, 16'h0000, 3, -1, -1);
    step = "ena_drop"; txn(1, 0, 16'h0510, 16'h0000, 4, -1, 2);
    step = "ena_hold";
    if_addr = 16'h0520; if_req = 1'b1; n = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_start || busy) n++;
    end
    chk("no_grant", n, 0);
    if_req = 1'b0; ena = 1'b1;
    @(negedge clk);

    step = "req_drop";
    eng_xor = 16'h0F0F; eng_d = 4; if_addr = 16'h0777; if_req = 1'b1; n = 0; nack = 0;
    for (int rel = 1; rel <= 10; rel++) begin
      @(negedge clk);
      if (rel == 2) if_req = 1'b0;
      if (mem_start) n++;
      if (if_ack || dm_ack) nack++;
    end
    m_last = 1'b0;
    chk("starts", n, 1);
    chk("acks", nack, 0);
    chk("if_rdata_kept", if_rdata, m_rd[0]);
    chk("busy", busy, 1'b0);

    step = "rst_mid";
    eng_d = -1; if_addr = 16'h0600; if_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("busy", busy, 1'b0);
    chk("outs", {mem_start, mem_abort, if_ack, dm_ack}, 4'b0);
    chk("rdata", {if_rdata, dm_rdata}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1; m_cv = 1'b0; m_rd[0] = 16'h0; m_rd[1] = 16'h0;
    n = 0;
    repeat (T + 4) begin
      @(negedge clk);
      if (mem_abort || if_ack || dm_ack || busy) n++;
    end
    chk("quiet", n, 0);
    step = "rst_after"; eng_xor = 16'h2222; txn(1, 1, 16'h0610, 16'h0620, 2, -1, -1);

    step = "cache_fill";  eng_xor = 16'h1274; txn(1, 0, 16'h0040, 16'h0000, 2, -1, -1);
    step = "cache_rep";   txn(1, 0, 16'h0040, 16'h0000, 2, -1, -1);
    step = "cache_dm";    txn(0, 1, 16'h0000, 16'h0040, 1, -1, -1);
    step = "cache_rep2";  txn(1, 0, 16'h0040, 16'h0000, 2, -1, -1);
    flush_idle();
    step = "cache_flush"; txn(1, 0, 16'h0040, 16'h0000, 2, -1, -1);
    flush_idle();
    step = "flush_fill";  txn(1, 0, 16'h0040, 16'h0000, 2, 3, -1);
    step = "after_ff";    txn(1, 0, 16'h0040, 16'h0000, 2, -1, -1);
    step = "err_nofill";  txn(1, 0, 16'h0700, 16'h0000, T + 1, -1, -1);
    step = "err_rep";     txn(1, 0, 16'h0700, 16'h0000, 1, -1, -1);

    step = "random";
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      ra = ($urandom_range(0, 4) == 4) ? 16'($urandom) : tbl[$urandom_range(0, 3)];
      rb = ($urandom_range(0, 4) == 4) ? 16'($urandom) : tbl[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) eng_xor = 16'($urandom);
      if ($urandom_range(0, 7) == 0) flush_idle();
      txn(kind != 1, kind != 0, ra, rb, $urandom_range(0, T + 2), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
